// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (req 0) and MEM (req 1), one outstanding transaction.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid0,
  input  logic                  req_valid1,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  input  logic                  req_we0,
  input  logic                  req_we1,
  output logic                  req_ready0,
  output logic                  req_ready1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  grant_sel,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  state_t     state_q, state_d;
  logic       grant_q, grant_d;
  logic [3:0] starve_q, starve_d;
  logic       any_req, win, tmo_hit, done, arb;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) $error("STARVE_LIMIT out of range");
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) $error("TIMEOUT_CYCLES out of range");

  assign any_req = req_valid0 | req_valid1;
  assign win     = req_valid1 & ~(req_valid0 & (starve_q == 4'(STARVE_LIMIT)));
  assign done    = (state_q == WAIT_RSP) & (mem_rvalid | tmo_hit);
  assign arb     = any_req & ((state_q == IDLE) | done);

`ifdef ARB_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d;
  assign tmo_hit = (state_q == WAIT_RSP) & (tmo_q == 10'(TIMEOUT_CYCLES));
  assign tmo_d   = (state_q == ISSUE) ? '0 : (state_q == WAIT_RSP && !mem_rvalid) ? tmo_q + 10'd1 : tmo_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
    end
  end

  // Grants to req 1 only count toward starvation while req 0 is actually waiting.
  always_comb begin
    state_d  = arb ? ISSUE : (state_q == ISSUE && mem_ready) ? WAIT_RSP : done ? IDLE : state_q;
    grant_d  = arb ? win : grant_q;
    starve_d = !arb ? starve_q :
               !(win && req_valid0) ? 4'd0 :
               (starve_q == 4'(STARVE_LIMIT)) ? starve_q : starve_q + 4'd1;
  end

  always_comb begin
    mem_valid  = state_q == ISSUE;
    busy       = state_q != IDLE;
    grant_sel  = grant_q;
    mem_addr   = grant_q ? req_addr1 : req_addr0;
    mem_wdata  = grant_q ? req_wdata1 : req_wdata0;
    mem_we     = grant_q ? req_we1 : req_we0;
    req_ready0 = mem_valid & mem_ready & ~grant_q;
    req_ready1 = mem_valid & mem_ready & grant_q;
    rsp_valid0 = done & ~grant_q;
    rsp_valid1 = done & grant_q;
    rsp_err    = done & ~mem_rvalid;
    rsp_rdata  = (done && mem_rvalid) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven vectors plus hand sequences for starvation, stall, reset and timeout.
module tb_mem_port_arbiter;
  logic        clk = 0, rst_n = 0;
  logic        req_valid0 = 0, req_valid1 = 0, req_we0 = 0, req_we1 = 0;
  logic [31:0] req_addr0 = 0, req_addr1 = 0, req_wdata0 = 0, req_wdata1 = 0;
  logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata = 0;
  logic        mem_valid, mem_we, mem_ready = 0, mem_rvalid = 0, grant_sel, busy;
  int          n_cmp = 0, n_err = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_we0(req_we0), .req_we1(req_we1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .grant_sel(grant_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v0, v1; logic [31:0] a0, a1, wd0, wd1; logic we0, we1, mr, mrv; logic [31:0] rd;
    logic e_rr0, e_rr1, e_rv0, e_rv1, e_mv; logic [31:0] e_addr, e_wdata; logic e_we, e_gs, e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " req_ready0"}, 32'(req_ready0), 32'(v.e_rr0));
    chk({tag, " req_ready1"}, 32'(req_ready1), 32'(v.e_rr1));
    chk({tag, " rsp_valid0"}, 32'(rsp_valid0), 32'(v.e_rv0));
    chk({tag, " rsp_valid1"}, 32'(rsp_valid1), 32'(v.e_rv1));
    chk({tag, " mem_valid"}, 32'(mem_valid), 32'(v.e_mv));
    chk({tag, " mem_addr"}, mem_addr, v.e_addr);
    chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
    chk({tag, " mem_we"}, 32'(mem_we), 32'(v.e_we));
    chk({tag, " grant_sel"}, 32'(grant_sel), 32'(v.e_gs));
    chk({tag, " busy"}, 32'(busy), 32'(v.e_busy));
    chk({tag, " rsp_rdata"}, rsp_rdata, v.e_rdata);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  vec_t vecs[11];
  vec_t zero_v;
  logic got_g[10];
  logic exp_g[10];
  int   k, n, hits;

  initial begin
    // v0 v1 a0 a1 wd0 wd1 we0 we1 mr mrv rd | rr0 rr1 rv0 rv1 mv addr wdata we gs busy rdata
    vecs[0]  = '{0,0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,0,0};
    vecs[1]  = '{1,0,32'h40,0,0,0,0,0,0,0,0,                  0,0,0,0,0,32'h40,0,0,0,0,0};
    vecs[2]  = '{1,0,32'h40,0,0,0,0,0,1,0,0,                  1,0,0,0,1,32'h40,0,0,0,1,0};
    vecs[3]  = '{0,0,32'h40,0,0,0,0,0,0,1,32'hDEADBEEF,       0,0,1,0,0,32'h40,0,0,0,1,32'hDEADBEEF};
    vecs[4]  = '{0,0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0,0,0};
    vecs[5]  = '{1,1,32'h80,32'h100,0,32'h12345678,0,1,0,0,0, 0,0,0,0,0,32'h80,0,0,0,0,0};
    vecs[6]  = '{1,1,32'h80,32'h100,0,32'h12345678,0,1,1,0,0, 0,1,0,0,1,32'h100,32'h12345678,1,1,1,0};
    vecs[7]  = '{1,0,32'h80,32'h100,0,32'h12345678,0,1,0,1,32'h600D, 0,0,0,1,0,32'h100,32'h12345678,1,1,1,32'h600D};
    vecs[8]  = '{1,0,32'h80,32'h100,0,32'h12345678,0,1,1,0,0, 1,0,0,0,1,32'h80,0,0,0,1,0};
    vecs[9]  = '{0,0,32'h80,0,0,0,0,0,0,1,32'hCAFEF00D,       0,0,1,0,0,32'h80,0,0,0,1,32'hCAFEF00D};
    vecs[10] = '{0,0,0,0,0,0,0,0,0,1,32'h55,                  0,0,0,0,0,0,0,0,0,0,0};
    zero_v = vecs[0];
    exp_g = '{1,1,1,1,0,1,1,1,1,0};

    repeat (2) tick();
    chk_all("reset", zero_v);
    rst_n = 1;
    tick();
    chk_all("post_reset", zero_v);

    for (int i = 0; i < 11; i++) begin
      {req_valid0, req_valid1, req_addr0, req_addr1} = {vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].a1};
      {req_wdata0, req_wdata1, req_we0, req_we1} = {vecs[i].wd0, vecs[i].wd1, vecs[i].we0, vecs[i].we1};
      {mem_ready, mem_rvalid, mem_rdata} = {vecs[i].mr, vecs[i].mrv, vecs[i].rd};
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i]);
      tick();
    end
    mem_rvalid = 0;

    // Anti-starvation: both requesters always valid, zero-wait memory.
    {req_valid0, req_valid1, req_we1, mem_ready, mem_rvalid} = 5'b11011;
    k = 0;
    for (int c = 0; c < 40 && k < 10; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        got_g[k] = grant_sel;
        k++;
      end
    end
    chk("starve_grant_count", k, 10);
    for (int i = 0; i < k; i++) chk($sformatf("starve_grant%0d", i), 32'(got_g[i]), 32'(exp_g[i]));
    tick();
    {req_valid0, req_valid1} = 2'b00;
    tick();
    {mem_ready, mem_rvalid} = 2'b00;
    tick();
    chk("starve_idle_busy", 32'(busy), 0);

    // Stall with mem_ready low, then reset while waiting for the response.
    {req_valid0, req_addr0, req_wdata0, req_we0} = {1'b1, 32'h200, 32'hAAAA, 1'b1};
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_valid", 32'(mem_valid), 1);
      chk("stall_addr", mem_addr, 32'h200);
      chk("stall_wdata", mem_wdata, 32'hAAAA);
      chk("stall_ready", 32'({req_ready0, req_ready1}), 0);
      tick();
    end
    mem_ready = 1;
    tick();
    {req_valid0, req_we0, mem_ready} = 3'b000;
    @(negedge clk);
    chk("wait_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    tick();
    rst_n = 1;
    {mem_rvalid, mem_rdata} = {1'b1, 32'h77};
    @(negedge clk);
    chk("late_rvalid_dropped", 32'({rsp_valid0, rsp_valid1}), 0);
    chk("late_rvalid_busy", 32'(busy), 0);
    tick();
    mem_rvalid = 0;

    // Response watchdog: no mem_rvalid after the request is accepted.
    {req_valid0, req_addr0, mem_ready} = {1'b1, 32'h300, 1'b1};
    tick();
    tick();
    {req_valid0, mem_ready} = 2'b00;
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (rsp_valid0) break;
      tick();
      n++;
    end
    chk("timeout_cycles", n, 8);
    chk("timeout_err", 32'(rsp_err), 1);
    chk("timeout_rdata", rsp_rdata, 0);
    tick();
`else
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      hits += int'(rsp_valid0 | rsp_valid1 | rsp_err);
      tick();
    end
    chk("no_timeout_rsp", hits, 0);
    {mem_rvalid, mem_rdata} = {1'b1, 32'h99};
    @(negedge clk);
    chk("late_rsp_valid0", 32'(rsp_valid0), 1);
    chk("late_rsp_err", 32'(rsp_err), 0);
    chk("late_rsp_rdata", rsp_rdata, 32'h99);
    tick();
    mem_rvalid = 0;
`endif
    tick();
    chk("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
